// File: rtl/shift_register_ctrl_if.sv
// ----------------------------------------------------------------------------
// shift_register_ctrl_if
//   Bundles the word-producer handshake and the shift-register control bus of
//   shift_register_ctrl. clk and reset stay plain ports on the controller.
//
//   Producer -> controller : start, abort, din[N-1:0]
//   Controller -> producer : ready, busy, done, bit_idx[$clog2(N)-1:0]
//   Controller -> register : sr_load, sr_shift, sr_data[N-1:0]
//
//   master : the producer / observer side (drives start, abort, din)
//   slave  : the controller side
// ----------------------------------------------------------------------------
interface shift_register_ctrl_if #(
    parameter int N = 4
);
    localparam int BW = $clog2(N);

    logic          start;
    logic          abort;
    logic [N-1:0]  din;
    logic          ready;
    logic          sr_load;
    logic [N-1:0]  sr_data;
    logic          sr_shift;
    logic          busy;
    logic          done;
    logic [BW-1:0] bit_idx;

    modport master (
        output start, abort, din,
        input  ready, sr_load, sr_data, sr_shift, busy, done, bit_idx
    );

    modport slave (
        input  start, abort, din,
        output ready, sr_load, sr_data, sr_shift, busy, done, bit_idx
    );
endinterface

// File: rtl/shift_register_ctrl.sv
// ----------------------------------------------------------------------------
// shift_register_ctrl
//   Sequencer for an N-bit parallel-load / right-shift register (LSB-first
//   serial out). Accepts a word on start/ready, issues one load strobe, then
//   exactly N shift strobes spaced DIV clocks apart, then a one-cycle done.
//
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   synchronous, active-high reset
//     bus    slave modport of shift_register_ctrl_if
//              start/abort/din in; ready/busy/done/bit_idx out;
//              sr_load/sr_shift/sr_data to the shift register
//
//   State  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; ready=1
//   LOAD   | one-cycle sr_load with the captured word
//   SHIFT  | bit-period timing; sr_shift on the last clock of each period
//   DONE   | one-cycle done pulse, then back to IDLE
// ----------------------------------------------------------------------------
module shift_register_ctrl #(
    parameter int N   = 4,
    parameter int DIV = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_register_ctrl_if.slave bus
);
    localparam int BW = $clog2(N);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [N-1:0]  data_q, data_d;
    logic          shift_tick;

    // Last clock of a bit period while shifting.
    assign shift_tick = (state_q == S_SHIFT) && (div_cnt_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;

        case (state_q)
            S_IDLE: begin
                // abort beats a simultaneous start
                if (bus.start && !bus.abort) begin
                    data_d    = bus.din;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (shift_tick) begin
                    div_cnt_d = '0;
                    // bit_cnt parks at N-1 after the final shift so it fits BW bits
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort returns to IDLE from any active state; captured word is kept.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            div_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    assign bus.ready    = (state_q == S_IDLE);
    assign bus.sr_load  = (state_q == S_LOAD);
    assign bus.sr_shift = shift_tick;
    assign bus.busy     = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign bus.done     = (state_q == S_DONE);
    assign bus.sr_data  = data_q;
    assign bus.bit_idx  = bit_cnt_q;

endmodule
